branch_update_queue: RTL and testbench

Collects resolved branches from the three execute lanes and buffers them in an in-order FIFO. Drains them at a configurable rate onto the three predictor-update ports (`update_prediction_pc_N` / `update_prediction_valid_i_N` / `misprediction_N`) of the superscalar fetch-stage jump controller. It is the producer side of the predictor training interface: the jump controller consumes what this block emits. The queue decouples bursty resolution traffic (up to 3 per cycle) from a narrower predictor write bandwidth.

---
 rtl/branch_update_queue.sv | 194 +++++++++++++++++++
 tb/tb_branch_update_queue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_update_queue.sv
// branch_update_queue: in-order FIFO of resolved branches draining onto predictor update ports.
// Optional statistics counters enabled by defining BRANCH_UPDATE_STATS_EN.
module branch_update_queue #(
  parameter int SIZE  = 32,
  parameter int DEPTH = 8,
  parameter int DRAIN = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       resolve_valid_i_0,
  input  logic [SIZE-1:0]            resolve_pc_0,
  input  logic                       resolve_pred_taken_0,
  input  logic                       resolve_taken_0,
  input  logic                       resolve_valid_i_1,
  input  logic [SIZE-1:0]            resolve_pc_1,
  input  logic                       resolve_pred_taken_1,
  input  logic                       resolve_taken_1,
  input  logic                       resolve_valid_i_2,
  input  logic [SIZE-1:0]            resolve_pc_2,
  input  logic                       resolve_pred_taken_2,
  input  logic                       resolve_taken_2,
  output logic                       resolve_ready_o,
  output logic                       drop_o,
  output logic [SIZE-1:0]            update_prediction_pc_0,
  output logic [SIZE-1:0]            update_prediction_pc_1,
  output logic [SIZE-1:0]            update_prediction_pc_2,
  output logic                       update_prediction_valid_o_0,
  output logic                       update_prediction_valid_o_1,
  output logic                       update_prediction_valid_o_2,
  output logic                       misprediction_0,
  output logic                       misprediction_1,
  output logic                       misprediction_2,
  output logic [$clog2(DEPTH):0]     queue_count_o,
  output logic [31:0]                stat_branches_o,
  output logic [31:0]                stat_mispredicts_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [SIZE-1:0] pc_mem [DEPTH];
  logic [DEPTH-1:0] mp_mem;

  logic [2:0]      in_v;
  logic [2:0]      in_mp;
  logic [SIZE-1:0] in_pc [3];

  logic            ready;
  logic [1:0]      off [3];
  logic [1:0]      n_push;
  logic [1:0]      n_pop;
  logic [2:0]      pop_sel;
  logic [AW-1:0]   w_idx [3];
  logic [AW-1:0]   r_idx [3];

  logic [SIZE-1:0] upd_pc [3];
  logic [2:0]      upd_v;
  logic [2:0]      upd_mp;

  assign in_v = {resolve_valid_i_2,
                 resolve_valid_i_1,
                 resolve_valid_i_0};
  assign in_mp = {resolve_pred_taken_2 ^ resolve_taken_2,
                  resolve_pred_taken_1 ^ resolve_taken_1,
                  resolve_pred_taken_0 ^ resolve_taken_0};
  assign in_pc[0] = resolve_pc_0;
  assign in_pc[1] = resolve_pc_1;
  assign in_pc[2] = resolve_pc_2;

  // Room for a full 3-lane push; depends on occupancy only.
  assign ready = count <= CW'(DEPTH - 3);

  // Lane compaction offsets, push/pop counts and ring indices.
  always_comb begin
    off[0] = 2'd0;
    off[1] = 2'(in_v[0]);
    off[2] = 2'(in_v[0]) + 2'(in_v[1]);
    n_push = 2'd0;
    if (ready)
      n_push = 2'(in_v[0]) + 2'(in_v[1]) + 2'(in_v[2]);
    if (count >= CW'(DRAIN))
      n_pop = 2'(DRAIN);
    else
      n_pop = count[1:0];
    for (int j = 0; j < 3; j++) begin
      pop_sel[j] = 2'(j) < n_pop;
      w_idx[j]   = wr_ptr + AW'(off[j]);
      r_idx[j]   = rd_ptr + AW'(j);
    end
  end

  // Pointer, occupancy and drop-pulse state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_o <= 1'b0;
    end else begin
      count  <= count + CW'(n_push) - CW'(n_pop);
      wr_ptr <= wr_ptr + AW'(n_push);
      rd_ptr <= rd_ptr + AW'(n_pop);
      drop_o <= (|in_v) & ~ready;
    end
  end

  // Entry storage; compacted lanes land in consecutive slots.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ready && in_v[i]) begin
        pc_mem[w_idx[i]] <= in_pc[i];
        mp_mem[w_idx[i]] <= in_mp[i];
      end
    end
  end

  // Registered update ports; oldest popped entry on port 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_v  <= '0;
      upd_mp <= '0;
      for (int j = 0; j < 3; j++)
        upd_pc[j] <= '0;
    end else begin
      for (int j = 0; j < 3; j++) begin
        if (pop_sel[j]) begin
          upd_v[j]  <= 1'b1;
          upd_mp[j] <= mp_mem[r_idx[j]];
          upd_pc[j] <= pc_mem[r_idx[j]];
        end else begin
          upd_v[j]  <= 1'b0;
          upd_mp[j] <= 1'b0;
          upd_pc[j] <= '0;
        end
      end
    end
  end

  assign resolve_ready_o             = ready;
  assign queue_count_o               = count;
  assign update_prediction_pc_0      = upd_pc[0];
  assign update_prediction_pc_1      = upd_pc[1];
  assign update_prediction_pc_2      = upd_pc[2];
  assign update_prediction_valid_o_0 = upd_v[0];
  assign update_prediction_valid_o_1 = upd_v[1];
  assign update_prediction_valid_o_2 = upd_v[2];
  assign misprediction_0             = upd_mp[0];
  assign misprediction_1             = upd_mp[1];
  assign misprediction_2             = upd_mp[2];

`ifdef BRANCH_UPDATE_STATS_EN
  logic [31:0] st_br;
  logic [31:0] st_mp;
  logic [1:0]  n_pop_mp;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [1:0]  b
  );
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? '1 : s[31:0];
  endfunction

  // Number of popped entries carrying a mispredict.
  always_comb begin
    n_pop_mp = 2'd0;
    for (int j = 0; j < 3; j++)
      n_pop_mp = n_pop_mp
               + 2'(pop_sel[j] & mp_mem[r_idx[j]]);
  end

  // Saturating counters, aligned with the update outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_br <= '0;
      st_mp <= '0;
    end else begin
      st_br <= sat_add(st_br, n_pop);
      st_mp <= sat_add(st_mp, n_pop_mp);
    end
  end

  assign stat_branches_o    = st_br;
  assign stat_mispredicts_o = st_mp;
`else
  assign stat_branches_o    = '0;
  assign stat_mispredicts_o = '0;
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// tb_branch_update_queue: directed table, corner sequences and random
// traffic against a queue-based reference model.
module tb_branch_update_queue;

  localparam int DEPTH = 8;
  localparam int DRAIN = 2;

  logic        clk;
  logic        reset;
  logic        v0, v1, v2;
  logic [31:0] p0, p1, p2;
  logic        pr0, pr1, pr2;
  logic        tk0, tk1, tk2;
  logic        resolve_ready_o;
  logic        drop_o;
  logic [31:0] upc0, upc1, upc2;
  logic        uv0, uv1, uv2;
  logic        um0, um1, um2;
  logic [3:0]  queue_count_o;
  logic [31:0] stat_branches_o;
  logic [31:0] stat_mispredicts_o;

  branch_update_queue #(
    .SIZE(32), .DEPTH(DEPTH), .DRAIN(DRAIN)
  ) dut (
    .clk(clk), .reset(reset),
    .resolve_valid_i_0(v0), .resolve_pc_0(p0),
    .resolve_pred_taken_0(pr0), .resolve_taken_0(tk0),
    .resolve_valid_i_1(v1), .resolve_pc_1(p1),
    .resolve_pred_taken_1(pr1), .resolve_taken_1(tk1),
    .resolve_valid_i_2(v2), .resolve_pc_2(p2),
    .resolve_pred_taken_2(pr2), .resolve_taken_2(tk2),
    .resolve_ready_o(resolve_ready_o),
    .drop_o(drop_o),
    .update_prediction_pc_0(upc0),
    .update_prediction_pc_1(upc1),
    .update_prediction_pc_2(upc2),
    .update_prediction_valid_o_0(uv0),
    .update_prediction_valid_o_1(uv1),
    .update_prediction_valid_o_2(uv2),
    .misprediction_0(um0),
    .misprediction_1(um1),
    .misprediction_2(um2),
    .queue_count_o(queue_count_o),
    .stat_branches_o(stat_branches_o),
    .stat_mispredicts_o(stat_mispredicts_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        mp;
  } ent_t;

  typedef struct {
    logic [2:0]  v;
    logic [31:0] a, b, c;
    logic [2:0]  ev;
    logic [31:0] e0, e1;
    int          ecnt;
  } vec_t;

  ent_t   mq[$];
  int     n_chk;
  int     n_fail;
  longint sb;
  longint sm;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] v,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] c,
                      input logic [2:0] pr,
                      input logic [2:0] tk);
    logic [31:0] pcs [3];
    logic [31:0] ep  [3];
    logic [2:0]  ev;
    logic [2:0]  em;
    bit          rdy;
    bit          edrop;
    int          np;
    ent_t        e;
    pcs[0] = a; pcs[1] = b; pcs[2] = c;
    {v2, v1, v0} = v;
    p0 = a; p1 = b; p2 = c;
    {pr2, pr1, pr0} = pr;
    {tk2, tk1, tk0} = tk;
    rdy = (DEPTH - mq.size()) >= 3;
    chk("ready", resolve_ready_o, rdy);
    ev = '0; em = '0;
    for (int k = 0; k < 3; k++) ep[k] = '0;
    np = mq.size() < DRAIN ? mq.size() : DRAIN;
    for (int k = 0; k < np; k++) begin
      e = mq.pop_front();
      ev[k] = 1'b1;
      ep[k] = e.pc;
      em[k] = e.mp;
      sb += 1;
      sm += e.mp;
    end
    edrop = (v != 0) && !rdy;
    if (rdy)
      for (int i = 0; i < 3; i++)
        if (v[i]) mq.push_back('{pcs[i], pr[i] ^ tk[i]});
    @(posedge clk);
    #1;
    chk("valid", {uv2, uv1, uv0}, ev);
    chk("mispred", {um2, um1, um0}, em);
    chk("pc0", upc0, ep[0]);
    chk("pc1", upc1, ep[1]);
    chk("pc2", upc2, ep[2]);
    chk("count", queue_count_o, mq.size());
    chk("drop", drop_o, edrop);
`ifdef BRANCH_UPDATE_STATS_EN
    chk("stat_br", stat_branches_o, sb);
    chk("stat_mp", stat_mispredicts_o, sm);
`else
    chk("stat_br", stat_branches_o, 0);
    chk("stat_mp", stat_mispredicts_o, 0);
`endif
  endtask

  task automatic idle();
    step(3'b000, 0, 0, 0, 3'b000, 3'b000);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && mq.size() > 0; i++) idle();
    idle();
    chk("drain_empty", queue_count_o, 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, {uv2, uv1, uv0}, 0);
    chk({tag, "_mp"}, {um2, um1, um0}, 0);
    chk({tag, "_pc"}, upc0 | upc1 | upc2, 0);
    chk({tag, "_cnt"}, queue_count_o, 0);
    chk({tag, "_ready"}, resolve_ready_o, 1);
    chk({tag, "_drop"}, drop_o, 0);
    chk({tag, "_sbr"}, stat_branches_o, 0);
    chk({tag, "_smp"}, stat_mispredicts_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [5];
    bit   seen;
    n_chk = 0; n_fail = 0; sb = 0; sm = 0;
    reset = 1'b0;
    {v2, v1, v0} = '0; p0 = '0; p1 = '0; p2 = '0;
    {pr2, pr1, pr0} = '0; {tk2, tk1, tk0} = '0;

    tbl[0] = '{3'b111, 32'h10, 32'h14, 32'h18,
               3'b000, 32'h0,  32'h0,  3};
    tbl[1] = '{3'b111, 32'h10, 32'h14, 32'h18,
               3'b011, 32'h10, 32'h14, 4};
    tbl[2] = '{3'b000, 32'h0,  32'h0,  32'h0,
               3'b011, 32'h18, 32'h10, 2};
    tbl[3] = '{3'b000, 32'h0,  32'h0,  32'h0,
               3'b011, 32'h14, 32'h18, 0};
    tbl[4] = '{3'b000, 32'h0,  32'h0,  32'h0,
               3'b000, 32'h0,  32'h0,  0};

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk);
    reset = 1'b1;

    // single resolve on lane 1, mispredicted
    step(3'b010, 0, 32'h100, 0, 3'b010, 3'b000);
    idle();
    chk("single_v", {uv2, uv1, uv0}, 3'b001);
    chk("single_pc", upc0, 32'h100);
    chk("single_mp", um0, 1);
    idle();

    // burst table
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].c,
           3'b000, 3'b000);
      chk($sformatf("tbl%0d_v", i), {uv2, uv1, uv0}, tbl[i].ev);
      chk($sformatf("tbl%0d_pc0", i), upc0, tbl[i].e0);
      chk($sformatf("tbl%0d_pc1", i), upc1, tbl[i].e1);
      chk($sformatf("tbl%0d_cnt", i), queue_count_o, tbl[i].ecnt);
    end

    // lane compaction
    step(3'b101, 32'h40, 32'h44, 32'h48, 3'b000, 3'b100);
    idle();
    chk("comp_v", {uv2, uv1, uv0}, 3'b011);
    chk("comp_pc0", upc0, 32'h40);
    chk("comp_pc1", upc1, 32'h48);
    chk("comp_mp", {um1, um0}, 2'b10);
    idle();

    // backpressure
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (!resolve_ready_o) seen = 1;
      else step(3'b111, 32'h200 + 32'(i * 16),
                32'h204 + 32'(i * 16), 32'h208 + 32'(i * 16),
                3'b000, 3'b000);
    end
    chk("bp_ready_low", resolve_ready_o, 0);
    chk("bp_count", queue_count_o, 6);
    step(3'b111, 32'hdead0, 32'hdead4, 32'hdead8, 3'b111, 3'b000);
    chk("bp_drop", drop_o, 1);
    chk("bp_cnt_after", queue_count_o, 4);
    drain();

    // random traffic with wrap-around
    for (int i = 0; i < 60; i++)
      step(3'($urandom_range(0, 7)),
           $urandom & 32'hfffffffc,
           $urandom & 32'hfffffffc,
           $urandom & 32'hfffffffc,
           3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)));
    drain();

    // reset mid-burst at count 5
    step(3'b111, 32'h300, 32'h304, 32'h308, 3'b000, 3'b000);
    step(3'b111, 32'h310, 32'h314, 32'h318, 3'b000, 3'b000);
    step(3'b111, 32'h320, 32'h324, 32'h328, 3'b000, 3'b000);
    chk("pre_rst_cnt", queue_count_o, 5);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("mid");
    mq.delete();
    sb = 0; sm = 0;
    @(negedge clk);
    reset = 1'b1;

    // ten pops, three mispredicts
    step(3'b111, 32'h400, 32'h404, 32'h408, 3'b101, 3'b000);
    step(3'b111, 32'h410, 32'h414, 32'h418, 3'b000, 3'b001);
    step(3'b111, 32'h420, 32'h424, 32'h428, 3'b111, 3'b111);
    step(3'b001, 32'h430, 32'h0,   32'h0,   3'b000, 3'b000);
    drain();
`ifdef BRANCH_UPDATE_STATS_EN
    chk("stat10", stat_branches_o, 10);
    chk("stat3", stat_mispredicts_o, 3);
`else
    chk("stat10_off", stat_branches_o, 0);
    chk("stat3_off", stat_mispredicts_o, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
